// File: rtl/render_pkg.sv
// Shared constants for the VGA-scanned sprite renderers (people, chair, apple).
package render_pkg;
    typedef enum logic {LEFT_DIR = 1'b0, RIGHT_DIR = 1'b1} dir_e;

    localparam int H_VIS   = 640;
    localparam int V_VIS   = 480;
    localparam int V_TOTAL = 525;

    localparam logic [11:0] KEY_COLOR = 12'hF0F;

    localparam int PEOPLE_W      = 20;
    localparam int PEOPLE_H      = 40;
    localparam int PEOPLE_FRAMES = 4;

    // Must agree with the movement controller's reset position.
    localparam logic [9:0] PEOPLE_RST_LEFT = 10'd320;
    localparam logic [9:0] PEOPLE_RST_UP   = 10'd240;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// Once-per-frame position latch plus walk-cycle animation for the player sprite.
module sprite_anim_ctrl #(
    parameter int FRAMES    = 4,
    parameter int ANIM_DIV  = 8,
    parameter int IDLE_HOLD = 4,
    parameter int AW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    x_i,
    input  logic [9:0]    y_i,
    input  logic [9:0]    people_left_i,
    input  logic [9:0]    people_up_i,
    input  logic          dir_i,
    output logic [9:0]    pl_o,
    output logic [9:0]    pu_o,
    output logic          dir_o,
    output logic [AW-1:0] anim_frame_o
);
    import render_pkg::*;

    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int IW = $clog2(IDLE_HOLD + 1);

    logic [9:0]    pl_q, pl_d, pu_q, pu_d;
    dir_e          dir_q, dir_d;
    logic [AW-1:0] anim_q, anim_d;
    logic [DW-1:0] div_q, div_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          match_q, match, frame_tick, moving;

    // The scan sits on (0,480) for several clocks; only its first clock ticks.
    assign match      = (x_i == 10'd0) && (y_i == 10'(V_VIS));
    assign frame_tick = match && !match_q;
    assign moving     = (people_left_i != pl_q) || (people_up_i != pu_q);

    always_comb begin
        pl_d   = pl_q;
        pu_d   = pu_q;
        dir_d  = dir_q;
        anim_d = anim_q;
        div_d  = div_q;
        idle_d = idle_q;
        if (frame_tick) begin
            pl_d  = people_left_i;
            pu_d  = people_up_i;
            dir_d = dir_e'(dir_i);
            if (moving) begin
                idle_d = '0;
                if (div_q == DW'(ANIM_DIV - 1)) begin
                    div_d  = '0;
                    anim_d = (anim_q == AW'(FRAMES - 1)) ? '0 : anim_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end else begin
                if (idle_q != IW'(IDLE_HOLD))
                    idle_d = idle_q + 1'b1;
                if (idle_d == IW'(IDLE_HOLD)) begin
                    anim_d = '0;
                    div_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pl_q    <= PEOPLE_RST_LEFT;
            pu_q    <= PEOPLE_RST_UP;
            dir_q   <= LEFT_DIR;
            anim_q  <= '0;
            div_q   <= '0;
            idle_q  <= IW'(IDLE_HOLD);
            match_q <= 1'b0;
        end else begin
            pl_q    <= pl_d;
            pu_q    <= pu_d;
            dir_q   <= dir_d;
            anim_q  <= anim_d;
            div_q   <= div_d;
            idle_q  <= idle_d;
            match_q <= match;
        end
    end

    assign pl_o         = pl_q;
    assign pu_o         = pu_q;
    assign dir_o        = dir_q;
    assign anim_frame_o = anim_q;
endmodule

// File: rtl/people_sprite_render.sv
// Player sprite renderer: hit test, registered ROM address, then keyed colour/enable.
module people_sprite_render #(
    parameter int          SPR_W     = render_pkg::PEOPLE_W,
    parameter int          SPR_H     = render_pkg::PEOPLE_H,
    parameter int          FRAMES    = render_pkg::PEOPLE_FRAMES,
    parameter int          ANIM_DIV  = 8,
    parameter int          IDLE_HOLD = 4,
    parameter logic [11:0] KEY_COLOR = render_pkg::KEY_COLOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  people_left,
    input  logic [9:0]  people_up,
    input  logic        dir,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic        people_en,
    output logic [11:0] people_rgb
);
    import render_pkg::*;

    localparam int AW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [AW-1:0] anim_frame;
    logic [9:0]    pl, pu;
    logic          dir_l;

    sprite_anim_ctrl #(
        .FRAMES    (FRAMES),
        .ANIM_DIV  (ANIM_DIV),
        .IDLE_HOLD (IDLE_HOLD),
        .AW        (AW)
    ) u_anim (
        .clk           (clk),
        .rst           (rst),
        .x_i           (x),
        .y_i           (y),
        .people_left_i (people_left),
        .people_up_i   (people_up),
        .dir_i         (dir),
        .pl_o          (pl),
        .pu_o          (pu),
        .dir_o         (dir_l),
        .anim_frame_o  (anim_frame)
    );

    // 11-bit compare so a sprite parked near 1023 cannot wrap back onto the screen.
    logic [10:0] x11, y11, pl11, pu11, col, row, col_m;
    logic        hit;

    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};
    assign pl11 = {1'b0, pl};
    assign pu11 = {1'b0, pu};

    // Horizontal blanking never shows the sprite, even when it clips the right edge.
    assign hit = (x11 >= pl11) && (x11 <= pl11 + 11'(SPR_W - 1)) && (x11 < 11'(H_VIS)) &&
                 (y11 >= pu11) && (y11 <= pu11 + 11'(SPR_H - 1)) && (y11 < 11'(V_VIS));

    assign col   = x11 - pl11;
    assign row   = y11 - pu11;
    assign col_m = (dir_l == RIGHT_DIR) ? col : 11'(SPR_W - 1) - col;

    logic [11:0] rom_addr_q, rom_addr_d;
    logic        hit_q;
    logic        en_q, en_d;
    logic [11:0] rgb_q, rgb_d;

    assign rom_addr_d = hit ? (12'(anim_frame) * 12'(SPR_W * SPR_H) + 12'(row) * 12'(SPR_W) + 12'(col_m))
                            : rom_addr_q;

    assign en_d  = hit_q && (rom_data != KEY_COLOR);
    assign rgb_d = en_d ? rom_data : 12'h000;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            en_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_q      <= hit;
            en_q       <= en_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign people_en  = en_q;
    assign people_rgb = rgb_q;
endmodule

// File: tb/tb_people_sprite_render.sv
// Randomised scoreboard bench for people_sprite_render against a frame-level sprite model.
module tb_people_sprite_render;
    localparam int SPR_W = 20, SPR_H = 40, FRAMES = 4, ANIM_DIV = 8, IDLE_HOLD = 4;
    localparam logic [11:0] KEY = render_pkg::KEY_COLOR;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y, people_left, people_up;
    logic        dir;
    logic [11:0] rom_addr, rom_data, people_rgb;
    logic        people_en;
    logic [11:0] rom_mem [4096];

    always #5 clk = ~clk;
    assign rom_data = rom_mem[rom_addr];

    people_sprite_render #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .ANIM_DIV(ANIM_DIV), .IDLE_HOLD(IDLE_HOLD), .KEY_COLOR(KEY)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .people_left(people_left), .people_up(people_up), .dir(dir),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .people_en(people_en), .people_rgb(people_rgb)
    );

    int n_tests = 0, n_fail = 0;
    int q_addr[$], q_en[$], q_rgb[$];

    // Stimulus-side inputs, applied to the DUT together with each pixel.
    int rst_in, pl_in, pu_in, dir_in;

    // Reference state: what the renderer should be showing this frame.
    int m_pl, m_pu, m_dir, m_walk, m_idle, m_addr;
    bit m_prev_match;

    task automatic model_reset();
        m_pl = 320; m_pu = 240; m_dir = 0;
        m_walk = 0; m_idle = IDLE_HOLD; m_addr = 0; m_prev_match = 0;
    endtask

    function automatic int cur_frame();
        return (m_walk / ANIM_DIV) % FRAMES;
    endfunction

    task automatic model_tick();
        bit mv;
        mv = (pl_in != m_pl) || (pu_in != m_pu);
        m_pl = pl_in; m_pu = pu_in; m_dir = dir_in;
        if (mv) begin
            m_idle = 0;
            m_walk++;
        end else begin
            if (m_idle < IDLE_HOLD) m_idle++;
            if (m_idle == IDLE_HOLD) m_walk = 0;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q_addr.size() > 1) check("rom_addr", int'(rom_addr), q_addr.pop_front());
        if (q_en.size() > 2) begin
            check("people_en", int'(people_en), q_en.pop_front());
            check("people_rgb", int'(people_rgb), q_rgb.pop_front());
        end
    end

    task automatic drive(input int px_in, input int py_in);
        int px, py, col, row, en;
        bit match, tick, hit;
        px = (px_in < 0) ? 0 : (px_in > 1023 ? 1023 : px_in);
        py = (py_in < 0) ? 0 : (py_in > 1023 ? 1023 : py_in);
        @(posedge clk); #1;
        x = 10'(px); y = 10'(py); rst = (rst_in != 0);
        people_left = 10'(pl_in); people_up = 10'(pu_in); dir = dir_in[0];
        if (rst_in != 0) begin
            model_reset();
            q_addr.push_back(0);
            // The previous pixel's colour stage is also cleared by this reset.
            if (q_en.size() > 0) begin
                q_en[q_en.size()-1] = 0;
                q_rgb[q_rgb.size()-1] = 0;
            end
            q_en.push_back(0); q_rgb.push_back(0);
            return;
        end
        match = (px == 0) && (py == 480);
        tick = match && !m_prev_match;
        m_prev_match = match;
        hit = px >= m_pl && px <= m_pl + SPR_W - 1 && px < 640 &&
              py >= m_pu && py <= m_pu + SPR_H - 1 && py < 480;
        if (hit) begin
            col = px - m_pl;
            row = py - m_pu;
            if (m_dir == 0) col = SPR_W - 1 - col;
            m_addr = cur_frame() * SPR_W * SPR_H + row * SPR_W + col;
        end
        q_addr.push_back(m_addr);
        en = (hit && rom_mem[m_addr] != KEY) ? 1 : 0;
        q_en.push_back(en);
        q_rgb.push_back(en != 0 ? int'(rom_mem[m_addr]) : 0);
        if (tick) model_tick();
    endtask

    // One abbreviated video frame: vertical-blank tick, then n scattered pixels.
    task automatic frame(input int n, input bit allow_rst);
        int r;
        repeat ($urandom_range(1, 3)) drive(0, 480);
        for (int i = 0; i < n; i++) begin
            rst_in = (allow_rst && $urandom_range(0, 40) == 0) ? 1 : 0;
            r = $urandom_range(0, 3);
            if (r == 0) drive($urandom_range(0, 799), $urandom_range(0, 524));
            else drive(m_pl - 1 + $urandom_range(0, SPR_W + 1), m_pu - 1 + $urandom_range(0, SPR_H + 1));
        end
        rst_in = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int v;
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 3) == 0) rom_mem[i] = KEY;
            else begin
                v = $urandom & 12'hFFF;
                if (12'(v) == KEY) v = v ^ 1;
                rom_mem[i] = 12'(v);
            end
        end
        rst = 1'b1; x = '0; y = '0; people_left = 10'd320; people_up = 10'd240; dir = 1'b0;
        rst_in = 1; pl_in = 320; pu_in = 240; dir_in = 0;
        model_reset();

        // Reset, then a pixel inside the reset-position sprite (mirrored address 209).
        repeat (3) drive(330, 250);
        rst_in = 0;
        repeat (4) drive(330, 250);
        drive(329, 250);
        drive(320, 240);

        // Right-facing at (100,100): pixel (105,102) -> address 45.
        pl_in = 100; pu_in = 100; dir_in = 1;
        frame(0, 0);
        repeat (3) drive(105, 102);
        frame(6, 0);

        // Walk cycle over 32 moving frames.
        for (int f = 0; f < 32; f++) begin
            pl_in += 2;
            frame(6, 0);
        end
        for (int f = 0; f < 40 && cur_frame() != 2; f++) begin
            pl_in += 2;
            frame(3, 0);
        end
        // Stop: idle fallback after the hold period; then a direction flip without motion.
        repeat (6) frame(6, 0);
        dir_in = 0;
        frame(6, 0);

        // Mid-frame move is ignored until the next tick.
        pl_in = 100; pu_in = 180;
        frame(0, 0);
        for (int r = 200; r < 220; r += 3) drive(100 + (r % SPR_W), r);
        pl_in = 300;
        for (int r = 200; r < 220; r += 3) drive(100 + (r % SPR_W), r);
        drive(305, 205);
        frame(8, 0);

        // Right-edge clip at 630, and an underflowed 1022 that never hits.
        pl_in = 630; pu_in = 200;
        frame(0, 0);
        for (int c = 625; c < 655; c += 2) drive(c, 210);
        pl_in = 1022; pu_in = 300;
        frame(0, 0);
        for (int c = 0; c < 24; c++) drive(c < 12 ? 1010 + c : c, 300 + c);

        // Randomised frames with occasional mid-frame resets.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) != 0) begin
                pl_in = $urandom_range(0, 700);
                pu_in = $urandom_range(0, 500);
            end
            dir_in = $urandom_range(0, 1);
            frame(10, 1);
        end

        repeat (4) drive(700, 500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
